interval_timer: RTL and testbench



---
 rtl/interval_timer.sv | 129 ++++++++++++
 tb/tb_interval_timer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer.
// A start loads period/prescale/mode and enters RUN; every prescale+1 clocks
// one step is taken, and the step that finds count==1 emits a one-cycle tick,
// sets the sticky irq and either reloads (periodic) or returns to IDLE (one-shot).
module interval_timer #(
    parameter int Width         = 16,
    parameter int PrescaleWidth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [Width-1:0]         period,
    input  logic [PrescaleWidth-1:0] prescale,
    input  logic                     auto_reload,
    input  logic                     irq_clear,
    output logic                     busy,
    output logic [Width-1:0]         count,
    output logic                     tick,
    output logic                     irq,
    output logic                     overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [Width-1:0]         CNT_ZERO = {Width{1'b0}};
    localparam logic [Width-1:0]         CNT_ONE  = {{(Width-1){1'b0}}, 1'b1};
    localparam logic [PrescaleWidth-1:0] PSC_ZERO = {PrescaleWidth{1'b0}};
    localparam logic [PrescaleWidth-1:0] PSC_ONE  = {{(PrescaleWidth-1){1'b0}}, 1'b1};

    state_t                     state_r;
    logic [PrescaleWidth-1:0]   presc_r;
    logic [Width-1:0]           period_r;
    logic [PrescaleWidth-1:0]   prescale_r;
    logic                       mode_r;

    logic                       load_s;
    logic                       abort_s;
    logic                       step_s;
    logic                       term_s;

    // Command decode: stop beats start beats step; a zero period is not a start.
    always_comb begin
        load_s  = 1'b0;
        abort_s = 1'b0;
        step_s  = 1'b0;
        term_s  = 1'b0;
        if (stop) begin
            abort_s = (state_r == RUN);
        end else if (start && (period != CNT_ZERO)) begin
            load_s = 1'b1;
        end else begin
            step_s = (state_r == RUN) && (presc_r == PSC_ZERO);
            term_s = step_s && (count == CNT_ONE);
        end
    end

    // Timer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            count      <= CNT_ZERO;
            tick       <= 1'b0;
            irq        <= 1'b0;
            overrun    <= 1'b0;
            presc_r    <= PSC_ZERO;
            period_r   <= CNT_ZERO;
            prescale_r <= PSC_ZERO;
            mode_r     <= 1'b0;
        end else begin
            tick <= term_s;

            if (abort_s) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                count   <= CNT_ZERO;
            end else if (load_s) begin
                period_r   <= period;
                prescale_r <= prescale;
                mode_r     <= auto_reload;
                count      <= period;
                presc_r    <= prescale;
                state_r    <= RUN;
                busy       <= 1'b1;
            end else if (state_r == RUN) begin
                if (presc_r == PSC_ZERO) begin
                    presc_r <= prescale_r;
                    if (count == CNT_ONE) begin
                        if (mode_r) begin
                            count <= period_r;
                        end else begin
                            count   <= CNT_ZERO;
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end else begin
                    presc_r <= presc_r - PSC_ONE;
                end
            end else begin
                state_r <= state_r;
            end

            // A new terminal count wins over a clear of the flag.
            if (term_s) begin
                irq <= 1'b1;
            end else if (irq_clear) begin
                irq <= 1'b0;
            end else begin
                irq <= irq;
            end

            if (irq_clear) begin
                overrun <= 1'b0;
            end else if (term_s && irq) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: a table of per-cycle vectors fed
// through an expected-value queue, plus hand sequences for prescaled periodic
// operation and asynchronous reset in the middle of an interval.
module tb_interval_timer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic [3:0]  prescale;
    logic        auto_reload;
    logic        irq_clear;
    logic        busy;
    logic [15:0] count;
    logic        tick;
    logic        irq;
    logic        overrun;

    int checks;
    int errors;

    typedef struct {
        logic        start;
        logic        stop;
        logic [15:0] period;
        logic [3:0]  prescale;
        logic        auto_reload;
        logic        irq_clear;
        logic        busy;
        logic [15:0] count;
        logic        tick;
        logic        irq;
        logic        overrun;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    interval_timer #(.Width(16), .PrescaleWidth(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .irq_clear   (irq_clear),
        .busy        (busy),
        .count       (count),
        .tick        (tick),
        .irq         (irq),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic [15:0] per,
                       input logic [3:0] psc, input logic ar, input logic clr,
                       input logic e_busy, input logic [15:0] e_count,
                       input logic e_tick, input logic e_irq, input logic e_ov);
        vec_t v;
        v.start = st; v.stop = sp; v.period = per; v.prescale = psc;
        v.auto_reload = ar; v.irq_clear = clr;
        v.busy = e_busy; v.count = e_count; v.tick = e_tick;
        v.irq = e_irq; v.overrun = e_ov;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; period = 16'd0; prescale = 4'd0;
        auto_reload = 1'b0; irq_clear = 1'b0;
    endtask

    initial begin
        vec_t e;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();

        //   st   sp   period  psc  ar   clr  | busy count  tick irq  ov
        // one-shot period 3
        add(1'b1,1'b0,16'd3, 4'd0,1'b0,1'b0, 1'b1,16'd3, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd2, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b0,16'd0, 1'b1,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b0,16'd0, 1'b0,1'b1,1'b0);
        // zero period in IDLE is ignored, then clear irq
        add(1'b1,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b0,16'd0, 1'b0,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b1, 1'b0,16'd0, 1'b0,1'b0,1'b0);
        // one-shot period 6; zero-period start at count 4 does not disturb it
        add(1'b1,1'b0,16'd6, 4'd0,1'b0,1'b0, 1'b1,16'd6, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd5, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd4, 1'b0,1'b0,1'b0);
        add(1'b1,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd3, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd2, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b0,1'b0,1'b0);
        // restart exactly on the terminal step: no tick, count=5
        add(1'b1,1'b0,16'd5, 4'd0,1'b0,1'b0, 1'b1,16'd5, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd4, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd3, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd2, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b0,1'b0,1'b0);
        // stop+start on the terminal step: stop wins, no tick
        add(1'b1,1'b1,16'd5, 4'd0,1'b0,1'b0, 1'b0,16'd0, 1'b0,1'b0,1'b0);
        add(1'b0,1'b1,16'd0, 4'd0,1'b0,1'b0, 1'b0,16'd0, 1'b0,1'b0,1'b0);
        // periodic period 2: overrun on second tick, clears
        add(1'b1,1'b0,16'd2, 4'd0,1'b1,1'b0, 1'b1,16'd2, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd2, 1'b1,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b0,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd2, 1'b1,1'b1,1'b1);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b1, 1'b1,16'd1, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd2, 1'b1,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b0,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b1, 1'b1,16'd2, 1'b1,1'b1,1'b0);
        add(1'b0,1'b1,16'd0, 4'd0,1'b0,1'b0, 1'b0,16'd0, 1'b0,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b1, 1'b0,16'd0, 1'b0,1'b0,1'b0);
        // period 1 periodic: tick every cycle, busy held
        add(1'b1,1'b0,16'd1, 4'd0,1'b1,1'b0, 1'b1,16'd1, 1'b0,1'b0,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b1,1'b1,1'b0);
        add(1'b0,1'b0,16'd0, 4'd0,1'b0,1'b0, 1'b1,16'd1, 1'b1,1'b1,1'b1);
        add(1'b0,1'b1,16'd0, 4'd0,1'b0,1'b1, 1'b0,16'd0, 1'b0,1'b0,1'b0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors through the expected-value queue
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start; stop = vecs[i].stop; period = vecs[i].period;
            prescale = vecs[i].prescale; auto_reload = vecs[i].auto_reload;
            irq_clear = vecs[i].irq_clear;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(e.busy));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(e.count));
            chk($sformatf("v%0d_tick", i), 32'(tick), 32'(e.tick));
            chk($sformatf("v%0d_irq", i), 32'(irq), 32'(e.irq));
            chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'(e.overrun));
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // prescaled periodic: period 2, prescale 3 -> tick every 8 edges
        @(negedge clk);
        idle_inputs();
        start = 1'b1; period = 16'd2; prescale = 4'd3; auto_reload = 1'b1;
        @(posedge clk);
        #1;
        chk("psc_start_count", 32'(count), 32'd2);
        @(negedge clk);
        idle_inputs();
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("psc_e%0d_tick", k), 32'(tick), ((k % 8) == 0) ? 32'd1 : 32'd0);
            chk($sformatf("psc_e%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("psc_e%0d_count", k), 32'(count),
                ((k % 8) >= 4) ? 32'd1 : 32'd2);
        end

        // asynchronous reset in the middle of an interval
        @(negedge clk);
        start = 1'b1; period = 16'd10; prescale = 4'd0; auto_reload = 1'b0;
        @(negedge clk);
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_count", 32'(count), 32'd6);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_busy", k), 32'(busy), 32'd0);
            chk($sformatf("post_rst%0d_count", k), 32'(count), 32'd0);
            chk($sformatf("post_rst%0d_tick", k), 32'(tick), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
